flow_ctrl: RTL
==============

Name: flow_ctrl

Overview:
- Control-transfer sequencer sitting beside the decode/execute stage.
- Accepts one decoded instruction at a time (opcode, immediate, condition fields, register operand value, current PC) and resolves JR, JPC, BRFL, CALL and RET.
- Owns a hardware return-address stack; drives the PC redirect and pipeline-flush pulses to fetch.
- Non-control opcodes are accepted and retired without a redirect.

Parameters:
DEPTH, 8, return-stack entries (power of 2, >=2)
SP_W, 3, stack-pointer width, equals log2(DEPTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  decoded instruction present
req_ready  out  1  block can accept an instruction
op  in  5  opcode, ISA encoding (LW=0 ... JR=13, JPC=14, BRFL=15, CALL=16, RET=17, NOP=18)
imm  in  26  JPC offset, two's complement
cond  in  4  BRFL required flag values
mask  in  4  BRFL flags to test
r_val  in  32  value of register R (JR/BRFL/CALL target)
pcounter  in  32  PC of the instruction
rflags  in  4  flag register
pc_load  out  1  one-cycle pulse: fetch loads pc_target
pc_target  out  32  redirect address
flush  out  1  one-cycle pulse, coincident with pc_load
done  out  1  one-cycle pulse: instruction retired
taken  out  1  qualifies done: redirect occurred
sp  out  SP_W+1  stack occupancy, 0..DEPTH
err_ovf  out  1  sticky: CALL with full stack
err_udf  out  1  sticky: RET with empty stack
err_clr  in  1  clears both sticky errors

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0 except req_ready=1; sp=0; stack contents don't-care. A reset mid-operation abandons the instruction, with no pc_load and no done.
- FSM states: IDLE, RESOLVE, REDIRECT.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op/imm/cond/mask/r_val/pcounter/rflags and go to RESOLVE.
  - Inputs are not re-sampled after acceptance.
- RESOLVE:
  - req_ready=0.
  - Compute taken and target from latched values:
    - JR: taken=1, target=r_val.
    - JPC: taken=1, target=pcounter + sign_extend(imm), modulo 2^32.
    - BRFL: taken = (((rflags XOR cond) AND mask) == 0); target=r_val. mask=0 means always taken.
    - CALL, stack not full: push pcounter+4 (mod 2^32), sp+1, taken=1, target=r_val.
    - CALL, stack full: no push, taken=0, err_ovf<=1.
    - RET, stack not empty: pop, sp-1, taken=1, target=popped value.
    - RET, stack empty: taken=0, err_udf<=1.
    - Every other opcode: taken=0.
  - If taken, go to REDIRECT. Otherwise pulse done=1 with taken=0 and go to IDLE.
- REDIRECT:
  - pc_load=1, flush=1, done=1, taken=1, pc_target valid for this cycle only.
  - Go to IDLE.
- Latency from the acceptance edge:
  - Not-taken instructions: done in the next cycle.
  - Taken instructions: pc_load/done two cycles after acceptance.
  - Throughput: one instruction per 2 cycles (not taken) or 3 cycles (taken).
- pc_target holds its last value when pc_load=0; fetch must ignore it.
- Stack:
  - LIFO; entry written at index sp on push, read at index sp-1 on pop.
  - sp saturates at 0 and DEPTH; errors guard both boundaries.
  - A push at sp=DEPTH-1 fills the stack; the next CALL overflows.
- Errors:
  - Sticky until err_clr=1.
  - If err_clr and a new error occur in the same cycle, the new error wins (flag ends at 1).
- done and pc_load are never asserted in IDLE.

Decomposition:
- Shared package isa_pkg:
  - 5-bit opcode constants LW..NOP (values above).
  - 4-bit ula_op subset.
  - Flag bit indices.
  - FSM state enum for flow_ctrl.
- One sub-module: return_stack.
  - DEPTH x 32 register array.
  - Interface: push, pop, din, dout, sp, full, empty.
  - Push and pop never occur in the same cycle.

Test Plan:
- JPC at pcounter=0x0000_0100 with imm=0x3FF_FFF0 (-16) -> two cycles after acceptance: pc_load=1, flush=1, pc_target=0x0000_00F0, done=1, taken=1.
- BRFL, rflags=4'b1010, cond=4'b1000, mask=4'b1100, r_val=0x40 -> taken, pc_target=0x40. Same with mask=4'b0110 -> done with taken=0 one cycle after acceptance, no pc_load.
- CALL r_val=0x200 at pcounter=0x10, then RET -> sp 0->1->0; the RET redirect has pc_target=0x14.
- DEPTH+1 consecutive CALLs -> first 8 redirect; 9th gives taken=0, err_ovf=1, sp=8. err_clr pulse -> err_ovf=0.
- RET at sp=0 -> err_udf=1, no pc_load. err_clr in the same cycle as a second RET at sp=0 -> err_udf remains 1.
- CALL accepted, reset asserted during RESOLVE -> outputs 0 immediately, sp=0, no pc_load; after release req_ready=1. Also: ADD (op=3) -> done with taken=0, sp unchanged.

Source files
------------

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared ISA constants, flag indices and flow_ctrl state type
package isa_pkg;

  // 5-bit opcode encoding
  localparam logic [4:0] OP_LW   = 5'd0;
  localparam logic [4:0] OP_SW   = 5'd1;
  localparam logic [4:0] OP_LI   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_CMP  = 5'd10;
  localparam logic [4:0] OP_MOV  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_JR   = 5'd13;
  localparam logic [4:0] OP_JPC  = 5'd14;
  localparam logic [4:0] OP_BRFL = 5'd15;
  localparam logic [4:0] OP_CALL = 5'd16;
  localparam logic [4:0] OP_RET  = 5'd17;
  localparam logic [4:0] OP_NOP  = 5'd18;

  // ALU operation subset used by the execute stage
  localparam logic [3:0] ULA_ADD = 4'd0;
  localparam logic [3:0] ULA_SUB = 4'd1;
  localparam logic [3:0] ULA_AND = 4'd2;
  localparam logic [3:0] ULA_OR  = 4'd3;
  localparam logic [3:0] ULA_XOR = 4'd4;
  localparam logic [3:0] ULA_SHL = 4'd5;
  localparam logic [3:0] ULA_SHR = 4'd6;

  // Bit positions inside the 4-bit flag register
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    FC_IDLE     = 2'd0,
    FC_RESOLVE  = 2'd1,
    FC_REDIRECT = 2'd2
  } fc_state_t;

  // JPC offsets are 26-bit two's complement
  function automatic logic [31:0] sext26(input logic [25:0] v);
    return {{6{v[25]}}, v};
  endfunction

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - LIFO of return addresses with occupancy counter
module return_stack
  import isa_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SP_W  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [31:0]     din,
  output logic [31:0]     dout,
  output logic [SP_W:0]   sp,
  output logic            full,
  output logic            empty
);

  localparam logic [SP_W:0]   SP_ONE  = 1;
  localparam logic [SP_W:0]   SP_MAX  = (SP_W+1)'(DEPTH);
  localparam logic [SP_W-1:0] IDX_ONE = 1;

  logic [31:0]     mem [DEPTH];
  logic [SP_W:0]   sp_q;
  logic [SP_W-1:0] top_idx;

  assign full    = (sp_q == SP_MAX);
  assign empty   = (sp_q == '0);
  assign sp      = sp_q;
  // At sp=DEPTH the low bits wrap to 0, so subtracting one still lands on the top entry
  assign top_idx = sp_q[SP_W-1:0] - IDX_ONE;
  assign dout    = mem[top_idx];

  // Occupancy counter, saturating at both ends
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + SP_ONE;
    end else if (pop && !empty) begin
      sp_q <= sp_q - SP_ONE;
    end
  end

  // Entry storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp_q[SP_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/flow_ctrl.sv
// rtl/flow_ctrl.sv - control-transfer sequencer driving PC redirect and flush
module flow_ctrl
  import isa_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SP_W  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      op,
  input  logic [25:0]     imm,
  input  logic [3:0]      cond,
  input  logic [3:0]      mask,
  input  logic [31:0]     r_val,
  input  logic [31:0]     pcounter,
  input  logic [3:0]      rflags,
  output logic            pc_load,
  output logic [31:0]     pc_target,
  output logic            flush,
  output logic            done,
  output logic            taken,
  output logic [SP_W:0]   sp,
  output logic            err_ovf,
  output logic            err_udf,
  input  logic            err_clr
);

  fc_state_t   state, state_n;

  logic [4:0]  l_op;
  logic [25:0] l_imm;
  logic [3:0]  l_cond, l_mask, l_flags;
  logic [31:0] l_r_val, l_pc;

  logic        res_taken;
  logic [31:0] res_target;
  logic        st_push, st_pop, st_full, st_empty;
  logic        set_ovf, set_udf;
  logic [31:0] st_dout;
  logic        accept;

  assign accept = (state == FC_IDLE) && req_valid;

  return_stack #(.DEPTH(DEPTH), .SP_W(SP_W)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (st_push),
    .pop   (st_pop),
    .din   (l_pc + 32'd4),
    .dout  (st_dout),
    .sp    (sp),
    .full  (st_full),
    .empty (st_empty)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FC_IDLE;
    else        state <= state_n;
  end

  // Next state, resolution of the latched instruction and output pulses
  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    pc_load    = 1'b0;
    flush      = 1'b0;
    done       = 1'b0;
    taken      = 1'b0;
    res_taken  = 1'b0;
    res_target = l_r_val;
    st_push    = 1'b0;
    st_pop     = 1'b0;
    set_ovf    = 1'b0;
    set_udf    = 1'b0;
    case (state)
      FC_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = FC_RESOLVE;
      end
      FC_RESOLVE: begin
        case (l_op)
          OP_JR:   res_taken = 1'b1;
          OP_JPC: begin
            res_taken  = 1'b1;
            res_target = l_pc + sext26(l_imm);
          end
          OP_BRFL: res_taken = (((l_flags ^ l_cond) & l_mask) == 4'b0000);
          OP_CALL: begin
            if (st_full) set_ovf = 1'b1;
            else begin
              st_push   = 1'b1;
              res_taken = 1'b1;
            end
          end
          OP_RET: begin
            if (st_empty) set_udf = 1'b1;
            else begin
              st_pop     = 1'b1;
              res_taken  = 1'b1;
              res_target = st_dout;
            end
          end
          default: res_taken = 1'b0;
        endcase
        if (res_taken) begin
          state_n = FC_REDIRECT;
        end else begin
          done    = 1'b1;
          state_n = FC_IDLE;
        end
      end
      FC_REDIRECT: begin
        pc_load = 1'b1;
        flush   = 1'b1;
        done    = 1'b1;
        taken   = 1'b1;
        state_n = FC_IDLE;
      end
      default: state_n = FC_IDLE;
    endcase
  end

  // Instruction capture on acceptance; inputs are ignored afterwards
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l_op    <= '0;
      l_imm   <= '0;
      l_cond  <= '0;
      l_mask  <= '0;
      l_r_val <= '0;
      l_pc    <= '0;
      l_flags <= '0;
    end else if (accept) begin
      l_op    <= op;
      l_imm   <= imm;
      l_cond  <= cond;
      l_mask  <= mask;
      l_r_val <= r_val;
      l_pc    <= pcounter;
      l_flags <= rflags;
    end
  end

  // Redirect address register, held between redirects
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_target <= '0;
    else if (state == FC_RESOLVE && res_taken) pc_target <= res_target;
  end

  // Sticky error flags; a new error outranks a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (set_ovf)      err_ovf <= 1'b1;
      else if (err_clr) err_ovf <= 1'b0;
      if (set_udf)      err_udf <= 1'b1;
      else if (err_clr) err_udf <= 1'b0;
    end
  end

endmodule
